// File: rtl/muldiv_pkg.sv
// Core-wide encodings for the multiply/divide unit: operation codes and
// the FSM states used by muldiv_unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } mdOp_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } mdState_t;

    // Signed variants are the even encodings (MULT, DIV).
    function automatic logic isSignedOp(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit_step.sv
// One radix-2 iteration of the shared multiply/divide datapath.
// Multiply: accIn = {partial product, remaining multiplier bits}; shift-add.
// Divide: accIn = {partial remainder, remaining dividend / quotient bits};
// restoring shift-subtract with a WIDTH+1-bit trial remainder.
module mdu_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 isDiv,
    input  logic [2*WIDTH-1:0]   accIn,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   accOut,
    output logic                 qBit
);

    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic [WIDTH+1:0] divTrial;

    // Compute both the multiply and divide step and select by mode.
    always_comb begin
        mulSum   = {1'b0, accIn[2*WIDTH-1:WIDTH]} + (accIn[0] ? {1'b0, operand} : '0);
        divShift = {accIn[2*WIDTH-1:WIDTH], accIn[WIDTH-1]};
        divTrial = {1'b0, divShift} - {2'b00, operand};
        qBit     = 1'b0;
        accOut   = '0;
        if (isDiv) begin
            qBit = ~divTrial[WIDTH+1];
            if (qBit) begin
                accOut = {divTrial[WIDTH-1:0], accIn[WIDTH-2:0], 1'b1};
            end else begin
                accOut = {divShift[WIDTH-1:0], accIn[WIDTH-2:0], 1'b0};
            end
        end else begin
            accOut = {mulSum, accIn[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Works on operand magnitudes for WIDTH cycles, then applies sign
// correction in one FIX cycle and writes HI/LO. Busy stalls the pipeline.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             Flush,
    input  logic             WeHi,
    input  logic             WeLo,
    input  logic [WIDTH-1:0] WData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CNTW = $clog2(WIDTH + 1);

    mdState_t         state;
    mdOp_t            opReg;
    logic [CNTW-1:0]  count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0] operandReg;
    logic [WIDTH-1:0] rawA;
    logic             negRes;
    logic             negRem;
    logic             divZero;
    logic [WIDTH-1:0] hiReg;
    logic [WIDTH-1:0] loReg;
    logic             doneReg;

    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic [2*WIDTH-1:0] stepAcc;
    logic               stepQBit;
    logic [WIDTH-1:0]   fixHi;
    logic [WIDTH-1:0]   fixLo;
    logic               startOk;

    mdu_step #(.WIDTH(WIDTH)) stepInst (
        .isDiv   (opReg[1]),
        .accIn   (acc),
        .operand (operandReg),
        .accOut  (stepAcc),
        .qBit    (stepQBit)
    );

    // Operand magnitudes for signed ops; -2^(WIDTH-1) maps to its unsigned magnitude.
    always_comb begin
        startOk = Start && !Flush;
        magA    = (isSignedOp(Op) && SrcA[WIDTH-1]) ? (~SrcA + 1'b1) : SrcA;
        magB    = (isSignedOp(Op) && SrcB[WIDTH-1]) ? (~SrcB + 1'b1) : SrcB;
    end

    // Sign correction and special-case results written to HI/LO in FIX.
    always_comb begin
        fixHi = '0;
        fixLo = '0;
        if (opReg[1]) begin
            if (divZero) begin
                fixHi = rawA;
                fixLo = '1;
            end else begin
                fixLo = (isSignedOp(opReg) && negRes) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
                fixHi = (isSignedOp(opReg) && negRem) ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
            end
        end else begin
            {fixHi, fixLo} = (isSignedOp(opReg) && negRes) ? (~acc + 1'b1) : acc;
        end
    end

    // FSM, iteration counter, operand latches and the HI/LO register file.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            opReg      <= MD_MULT;
            count      <= '0;
            acc        <= '0;
            operandReg <= '0;
            rawA       <= '0;
            negRes     <= 1'b0;
            negRem     <= 1'b0;
            divZero    <= 1'b0;
            hiReg      <= '0;
            loReg      <= '0;
            doneReg    <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (startOk) begin
                        opReg   <= mdOp_t'(Op);
                        rawA    <= SrcA;
                        divZero <= (SrcB == '0);
                        negRes  <= isSignedOp(Op) && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                        negRem  <= isSignedOp(Op) && SrcA[WIDTH-1];
                        count   <= CNTW'(WIDTH);
                        state   <= S_CALC;
                        if (Op[1]) begin
                            acc        <= {{WIDTH{1'b0}}, magA};
                            operandReg <= magB;
                        end else begin
                            acc        <= {{WIDTH{1'b0}}, magB};
                            operandReg <= magA;
                        end
                    end else begin
                        if (WeHi) hiReg <= WData;
                        if (WeLo) loReg <= WData;
                    end
                end
                S_CALC: begin
                    if (Flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc   <= stepAcc;
                        count <= count - 1'b1;
                        if (count == CNTW'(1)) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    if (!Flush) begin
                        hiReg   <= fixHi;
                        loReg   <= fixLo;
                        doneReg <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign Busy = (state != S_IDLE);
    assign Done = doneReg;
    assign Hi   = hiReg;
    assign Lo   = loReg;

    // The quotient bit is already folded into the accumulator by the step.
    logic unusedQBit;
    assign unusedQBit = stepQBit;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed boundary cases, randomized
// operations against an arithmetic reference model, and abort/write paths.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         Reset;
    logic         Start;
    logic [1:0]   Op;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic         Flush;
    logic         WeHi;
    logic         WeLo;
    logic [W-1:0] WData;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Hi;
    logic [W-1:0] Lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .Start (Start),
        .Op    (Op),
        .SrcA  (SrcA),
        .SrcB  (SrcB),
        .Flush (Flush),
        .WeHi  (WeHi),
        .WeLo  (WeLo),
        .WData (WData),
        .Busy  (Busy),
        .Done  (Done),
        .Hi    (Hi),
        .Lo    (Lo)
    );

    // Free-running clock.
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model from plain 64-bit arithmetic.
    function automatic void refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        hi = '0;
        lo = '0;
        if (op[1] && b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else begin
            case (op)
                2'b00: p = 64'(sa * sb);
                2'b01: p = 64'(ua * ub);
                2'b10: p = {64'(sa % sb)} << 32 | {32'd0, 32'(sa / sb)};
                default: p = {64'(ua % ub)} << 32 | {32'd0, 32'(ua / ub)};
            endcase
            hi = p[63:32];
            lo = p[31:0];
        end
    endfunction

    // Wait for Done on falling edges; counts Busy cycles on the way.
    task automatic waitDone(output int busyCycles, output int doneCycle);
        busyCycles = 0;
        doneCycle  = 0;
        for (int k = 1; k <= 100 && doneCycle == 0; k++) begin
            @(negedge CLK);
            if (Busy) busyCycles++;
            if (Done) doneCycle = k;
        end
    endtask

    // Issue one operation and wait for it to finish.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output int busyCycles, output int doneCycle);
        @(negedge CLK);
        Op    = op;
        SrcA  = a;
        SrcB  = b;
        Start = 1'b1;
        @(posedge CLK);
        #1 Start = 1'b0;
        waitDone(busyCycles, doneCycle);
    endtask

    task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int          busyCycles;
        int          doneCycle;
        logic [31:0] eHi;
        logic [31:0] eLo;
        applyStimulus(op, a, b, busyCycles, doneCycle);
        refModel(op, a, b, eHi, eLo);
        checkOutput({tag, ".doneCycle"}, 64'(doneCycle), 64'd34);
        checkOutput({tag, ".busyCycles"}, 64'(busyCycles), 64'd33);
        checkOutput({tag, ".hi"}, {32'd0, Hi}, {32'd0, eHi});
        checkOutput({tag, ".lo"}, {32'd0, Lo}, {32'd0, eLo});
        @(negedge CLK);
        checkOutput({tag, ".doneOnePulse"}, {63'd0, Done}, 64'd0);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(1, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int   busyCycles;
        int   doneCycle;
        int   doneSeen;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;

        Reset = 1'b1;
        Start = 1'b0;
        Op    = 2'b00;
        SrcA  = '0;
        SrcB  = '0;
        Flush = 1'b0;
        WeHi  = 1'b0;
        WeLo  = 1'b0;
        WData = '0;
        repeat (2) @(negedge CLK);
        checkOutput("reset.busy", {63'd0, Busy}, 64'd0);
        checkOutput("reset.done", {63'd0, Done}, 64'd0);
        checkOutput("reset.hilo", {Hi, Lo}, 64'd0);
        Reset = 1'b0;

        runOp("multNeg1x2", 2'b00, 32'hFFFF_FFFF, 32'h0000_0002);
        checkOutput("multNeg1x2.exact", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        runOp("multuNeg1x2", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002);
        checkOutput("multuNeg1x2.exact", {Hi, Lo}, 64'h0000_0001_FFFF_FFFE);
        runOp("divNeg7by2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        checkOutput("divNeg7by2.exact", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        runOp("divOverflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("divOverflow.exact", {Hi, Lo}, 64'h0000_0000_8000_0000);
        runOp("divuByZero", 2'b11, 32'h0000_0007, 32'h0000_0000);
        checkOutput("divuByZero.exact", {Hi, Lo}, 64'h0000_0007_FFFF_FFFF);
        runOp("divByZeroNeg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0000);
        checkOutput("divByZeroNeg.exact", {Hi, Lo}, 64'hFFFF_FFF9_FFFF_FFFF);
        runOp("multMinSq", 2'b00, 32'h8000_0000, 32'h8000_0000);
        checkOutput("multMinSq.exact", {Hi, Lo}, 64'h4000_0000_0000_0000);

        for (int i = 0; i < 20; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = pickOperand();
            b  = pickOperand();
            runOp($sformatf("rand%0d", i), op, a, b);
        end

        // MTHI and MTLO preload, then both together.
        @(negedge CLK);
        WeHi = 1'b1; WData = 32'h0000_1234;
        @(negedge CLK);
        WeHi = 1'b0; WeLo = 1'b1; WData = 32'h0000_5678;
        @(negedge CLK);
        WeLo = 1'b0;
        checkOutput("mtPreload", {Hi, Lo}, 64'h0000_1234_0000_5678);

        // Flush ten cycles into a DIVU.
        @(negedge CLK);
        Op = 2'b11; SrcA = 32'd100; SrcB = 32'd7; Start = 1'b1;
        @(posedge CLK);
        #1 Start = 1'b0;
        repeat (9) @(negedge CLK);
        Flush = 1'b1;
        @(posedge CLK);
        #1 Flush = 1'b0;
        @(negedge CLK);
        checkOutput("flush.busy", {63'd0, Busy}, 64'd0);
        doneSeen = 0;
        for (int k = 0; k < 40; k++) begin
            if (Done) doneSeen++;
            @(negedge CLK);
        end
        checkOutput("flush.noDone", 64'(doneSeen), 64'd0);
        checkOutput("flush.hilo", {Hi, Lo}, 64'h0000_1234_0000_5678);

        // Flush with Start in IDLE: Start ignored.
        Flush = 1'b1; Start = 1'b1; Op = 2'b01;
        @(posedge CLK);
        #1 begin Flush = 1'b0; Start = 1'b0; end
        @(negedge CLK);
        checkOutput("flushStartIdle.busy", {63'd0, Busy}, 64'd0);

        // WeHi and a second Start while busy are both ignored.
        @(negedge CLK);
        Op = 2'b01; SrcA = 32'd3; SrcB = 32'd5; Start = 1'b1;
        @(posedge CLK);
        #1 Start = 1'b0;
        repeat (4) @(negedge CLK);
        WeHi = 1'b1; WData = 32'hDEAD_BEEF;
        Start = 1'b1; Op = 2'b00; SrcA = 32'd9; SrcB = 32'd9;
        @(posedge CLK);
        #1 begin WeHi = 1'b0; Start = 1'b0; end
        @(negedge CLK);
        checkOutput("weHiBusy.hi", {32'd0, Hi}, 64'h0000_1234);
        waitDone(busyCycles, doneCycle);
        checkOutput("startBusy.doneSeen", {63'd0, doneCycle != 0}, 64'd1);
        checkOutput("startBusy.hilo", {Hi, Lo}, 64'd15);

        // Both MTHI and MTLO in one cycle.
        @(negedge CLK);
        WeHi = 1'b1; WeLo = 1'b1; WData = 32'h0000_0ABC;
        @(negedge CLK);
        WeHi = 1'b0; WeLo = 1'b0;
        checkOutput("mtBoth", {Hi, Lo}, 64'h0000_0ABC_0000_0ABC);

        // Asynchronous reset mid-CALC.
        @(negedge CLK);
        Op = 2'b10; SrcA = 32'd1000; SrcB = 32'd3; Start = 1'b1;
        @(posedge CLK);
        #1 Start = 1'b0;
        repeat (5) @(negedge CLK);
        #2 Reset = 1'b1;
        #1;
        checkOutput("resetMid.hilo", {Hi, Lo}, 64'd0);
        checkOutput("resetMid.busy", {63'd0, Busy}, 64'd0);
        @(negedge CLK);
        Reset = 1'b0;
        runOp("afterReset", 2'b10, 32'd1000, 32'hFFFF_FFFD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers.
- Sits beside the ALU in the Execute stage of the pipelined MIPS core.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO; drives HI/LO to the MFHI/MFLO result path.
- Busy feeds the hazard unit as a stall source. The existing single-cycle ALU datapath has no multi-cycle op, no HI/LO and no abort.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO.
- CNTW, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  request new operation; sampled only in IDLE.
- Op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- SrcA  in  WIDTH  multiplicand / dividend.
- SrcB  in  WIDTH  multiplier / divisor.
- Flush  in  1  abort in-flight operation (pipeline flush of E).
- WeHi  in  1  MTHI write enable.
- WeLo  in  1  MTLO write enable.
- WData  in  WIDTH  MTHI/MTLO data.
- Busy  out  1  operation in flight; stall request.
- Done  out  1  one-cycle pulse: HI/LO just updated by an operation.
- Hi  out  WIDTH  HI register.
- Lo  out  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, any state including mid-operation):
  - State to IDLE; Hi, Lo, counter and internal operands to 0.
  - Busy=0, Done=0.
- States: IDLE, CALC, FIX.
  - IDLE -> CALC: on Start=1 at an edge.
    - Latch Op.
    - Latch |SrcA| and |SrcB| for signed ops, raw values for unsigned.
    - Latch sign flags: product sign = A^B; quotient sign = A^B; remainder sign = A.
    - Counter to WIDTH.
  - CALC: one radix-2 step per cycle; counter decrements. When counter reaches 0, go to FIX.
    - Multiply: shift-add on a 2*WIDTH accumulator.
    - Divide: restoring shift-subtract, WIDTH+1-bit partial remainder.
  - FIX: one cycle.
    - Apply two's-complement sign correction.
    - Write Hi/Lo at the exiting edge; return to IDLE.
- Latency: Start sampled at edge 0 -> Hi/Lo updated at edge WIDTH+1 -> Done=1 for exactly the cycle after edge WIDTH+1.
- Busy: Moore output, 1 in CALC and FIX, 0 in IDLE. With WIDTH=32, Busy is high for 33 cycles.
- Done: registered, never high in two consecutive cycles.
- Results:
  - MULT/MULTU: {Hi,Lo} = full 2*WIDTH product.
  - DIV/DIVU: Lo = quotient, Hi = remainder.
  - Signed divide truncates toward zero; remainder takes the dividend's sign.
- Boundary cases:
  - Divide by zero (DIV or DIVU): Lo = all ones, Hi = SrcA unchanged (raw, not absolute value).
  - Signed overflow, DIV with A = -2^(WIDTH-1) and B = -1: Lo = 0x80..0, Hi = 0.
  - MULT of -2^(WIDTH-1) by itself: exact positive product 2^(2*WIDTH-2).
- Flush:
  - In CALC or FIX: next state IDLE; Hi/Lo unchanged; no Done.
  - Flush with Start in IDLE in the same cycle: Start ignored.
- Start while Busy: ignored; the in-flight operation is unaffected.
- MTHI/MTLO:
  - In IDLE with no accepted Start: WeHi/WeLo write WData at the edge. Both may be asserted together.
  - While Busy, or in the same cycle as an accepted Start: ignored. The hazard unit guarantees a stall here.
- Hi/Lo are register outputs, stable except at operation completion, MTHI/MTLO or Reset.

Decomposition:
- Shared package (core-wide defines):
  - Op encodings: MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11.
  - State encodings: S_IDLE, S_CALC, S_FIX.
- One natural sub-module: mdu_step.
  - Combinational single-iteration datapath.
  - Inputs: accumulator/remainder, operand, mode.
  - Outputs: next accumulator/remainder, next quotient bit.
- muldiv_unit holds the FSM, counter, sign handling, registers and the HI/LO file.

Test Plan (WIDTH=32):
- MULT A=0xFFFFFFFF, B=0x00000002 -> Done at cycle 34 after Start edge; Hi=0xFFFFFFFF, Lo=0xFFFFFFFE; Busy high 33 cycles.
- MULTU same operands -> Hi=0x00000001, Lo=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU A=7, B=0 -> Lo=0xFFFFFFFF, Hi=0x00000007.
- Abort and write paths:
  - Preload via MTHI/MTLO Hi=0x1234, Lo=0x5678.
  - Start DIVU; assert Flush 10 cycles in -> Busy=0 next cycle; no Done; Hi/Lo unchanged.
  - Repeat with Reset asserted mid-CALC -> Hi=Lo=0 immediately.
  - WeHi asserted while Busy -> Hi unchanged.
